// File: rtl/async_fifo_pkg.sv
// Shared constants and Gray-code helpers for the dual-clock FIFO.
// Helpers work at the widest legal pointer width; callers zero-extend and truncate.
package async_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH         = 4;
    localparam int DEFAULT_SIZE_AS_POWER_OF_2 = 3;
    localparam int MAX_PTR_WIDTH              = 17;

    typedef logic [MAX_PTR_WIDTH-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[MAX_PTR_WIDTH-1] = gray[MAX_PTR_WIDTH-1];
        for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_sync2.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the clk domain.
module async_fifo_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/async_fifo.sv
// Dual-clock FIFO with Gray pointers and registered full/empty flags.
// Define ASYNC_FIFO_ERR_FLAGS_EN to add sticky wOverflow/rUnderflow outputs.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int SIZE_AS_POWER_OF_2 = DEFAULT_SIZE_AS_POWER_OF_2,
    parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH
) (
    input  logic                  wClk,
    input  logic                  wRst,
    input  logic                  rClk,
    input  logic                  rRst,
    input  logic                  wEn,
    input  logic [DATA_WIDTH-1:0] wData,
    output logic                  full,
    input  logic                  rEn,
    output logic [DATA_WIDTH-1:0] rData,
    output logic                  empty
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  wOverflow,
    output logic                  rUnderflow
`endif
);

    localparam int N     = SIZE_AS_POWER_OF_2;
    localparam int PTR_W = N + 1;
    localparam int DEPTH = 1 << N;
    // A full FIFO shows the read pointer with its wrap bit and next bit inverted.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (N - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] w_bin;
    logic [PTR_W-1:0] w_gray;
    logic [PTR_W-1:0] w_bin_next;
    logic [PTR_W-1:0] w_gray_next;
    logic [PTR_W-1:0] rq2_gray;
    logic             w_push;

    logic [PTR_W-1:0] r_bin;
    logic [PTR_W-1:0] r_gray;
    logic [PTR_W-1:0] r_bin_next;
    logic [PTR_W-1:0] r_gray_next;
    logic [PTR_W-1:0] wq2_gray;
    logic             r_pop;

    // write domain
    assign w_push      = wEn && !full;
    assign w_bin_next  = w_bin + PTR_W'(w_push);
    assign w_gray_next = PTR_W'(bin2gray(ptr_t'(w_bin_next)));

    always_ff @(posedge wClk or posedge wRst) begin
        if (wRst) begin
            w_bin  <= '0;
            w_gray <= '0;
            full   <= 1'b0;
        end else begin
            w_bin  <= w_bin_next;
            w_gray <= w_gray_next;
            full   <= (w_gray_next == (rq2_gray ^ FULL_MASK));
        end
    end

    always_ff @(posedge wClk) begin
        if (w_push) begin
            mem[w_bin[N-1:0]] <= wData;
        end
    end

    // read domain
    assign r_pop       = rEn && !empty;
    assign r_bin_next  = r_bin + PTR_W'(r_pop);
    assign r_gray_next = PTR_W'(bin2gray(ptr_t'(r_bin_next)));

    always_ff @(posedge rClk or posedge rRst) begin
        if (rRst) begin
            r_bin  <= '0;
            r_gray <= '0;
            empty  <= 1'b1;
            rData  <= '0;
        end else begin
            r_bin  <= r_bin_next;
            r_gray <= r_gray_next;
            empty  <= (r_gray_next == wq2_gray);
            if (r_pop) begin
                rData <= mem[r_bin[N-1:0]];
            end
        end
    end

    async_fifo_sync2 #(.WIDTH(PTR_W)) u_sync_r2w (
        .clk (wClk),
        .rst (wRst),
        .d   (r_gray),
        .q   (rq2_gray)
    );

    async_fifo_sync2 #(.WIDTH(PTR_W)) u_sync_w2r (
        .clk (rClk),
        .rst (rRst),
        .d   (w_gray),
        .q   (wq2_gray)
    );

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge wClk or posedge wRst) begin
        if (wRst) begin
            wOverflow <= 1'b0;
        end else if (wEn && full) begin
            wOverflow <= 1'b1;
        end
    end

    always_ff @(posedge rClk or posedge rRst) begin
        if (rRst) begin
            rUnderflow <= 1'b0;
        end else if (rEn && empty) begin
            rUnderflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: table-driven bursts, corner sequences and a
// randomized stream scored against a queue model of the FIFO contents.
module tb_async_fifo;

    localparam int N     = 3;
    localparam int W     = 4;
    localparam int DEPTH = 1 << N;

    logic         wClk  = 1'b0;
    logic         rClk  = 1'b0;
    logic         wRst  = 1'b1;
    logic         rRst  = 1'b1;
    logic         wEn   = 1'b0;
    logic         rEn   = 1'b0;
    logic [W-1:0] wData = '0;
    logic         full;
    logic         empty;
    logic [W-1:0] rData;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic         wOverflow;
    logic         rUnderflow;
`endif

    int checks   = 0;
    int failures = 0;

    async_fifo #(.SIZE_AS_POWER_OF_2(N), .DATA_WIDTH(W)) dut (
        .wClk  (wClk),
        .wRst  (wRst),
        .rClk  (rClk),
        .rRst  (rRst),
        .wEn   (wEn),
        .wData (wData),
        .full  (full),
        .rEn   (rEn),
        .rData (rData),
        .empty (empty)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        ,
        .wOverflow  (wOverflow),
        .rUnderflow (rUnderflow)
`endif
    );

    // 3:10 clock ratio; write edges land on odd times, read edges on even times
    always #3  wClk = ~wClk;
    always #10 rClk = ~rClk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int           n_wr;
        logic [W-1:0] base;
        int           n_acc;
        int           n_rd;
        logic         exp_full;
        logic         exp_empty;
    } vec_t;

    vec_t         vecs [6];
    logic [W-1:0] tq [$];
    logic [W-1:0] last_rd = '0;

    task automatic write_burst(input int n, input logic [W-1:0] base, input int n_acc);
        logic [W-1:0] v;
        @(posedge wClk); #1;
        for (int i = 0; i < n; i++) begin
            v     = base + W'(i);
            wEn   = 1'b1;
            wData = v;
            if (i < n_acc) tq.push_back(v);
            @(posedge wClk); #1;
        end
        wEn = 1'b0;
    endtask

    task automatic read_burst(input int n, input string name);
        if (n > 0) begin
            @(posedge rClk); #1;
            rEn = 1'b1;
            for (int i = 0; i < n; i++) begin
                @(posedge rClk); #1;
                if (tq.size() == 0) begin
                    check_int({name, "_model_underrun"}, 0, 1);
                end else begin
                    last_rd = tq.pop_front();
                    check_data(name, rData, last_rd);
                end
            end
            rEn = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge rClk);
        #1;
    endtask

    // randomized-stream scoreboard
    logic         mon_on  = 1'b0;
    logic         wr_done = 1'b0;
    logic [W-1:0] mq [$];
    logic [W-1:0] r_exp;
    int           wr_acc  = 0;
    int           rd_acc  = 0;

    always @(posedge wClk) begin
        if (mon_on) begin
            if (mq.size() == DEPTH) check_bit("rand_full_safe", full, 1'b1);
            if (wEn && !full) begin
                mq.push_back(wData);
                wr_acc++;
            end
        end
    end

    always @(posedge rClk) begin
        if (mon_on) begin
            if (mq.size() == 0) check_bit("rand_empty_safe", empty, 1'b1);
            if (rEn && !empty) begin
                if (mq.size() == 0) begin
                    check_int("rand_read_without_data", 0, 1);
                end else begin
                    r_exp = mq.pop_front();
                    rd_acc++;
                    #1;
                    check_data("rand_data", rData, r_exp);
                end
            end
        end
    end

    initial begin
        vecs[0] = '{3, 4'h0, 3, 3, 1'b0, 1'b1};
        vecs[1] = '{8, 4'h0, 8, 0, 1'b1, 1'b0};
        vecs[2] = '{1, 4'h9, 0, 8, 1'b1, 1'b1};
        vecs[3] = '{5, 4'hA, 5, 2, 1'b0, 1'b0};
        vecs[4] = '{6, 4'h3, 5, 6, 1'b1, 1'b0};
        vecs[5] = '{0, 4'h0, 0, 2, 1'b0, 1'b1};

        repeat (3) @(posedge rClk);
        #1;
        wRst = 1'b0;
        rRst = 1'b0;
        @(posedge rClk); #1;
        check_bit("reset_empty", empty, 1'b1);
        check_bit("reset_full", full, 1'b0);
        check_data("reset_rdata", rData, 4'h0);

        for (int k = 0; k < 6; k++) begin
            write_burst(vecs[k].n_wr, vecs[k].base, vecs[k].n_acc);
            settle();
            check_bit($sformatf("vec%0d_full", k), full, vecs[k].exp_full);
            read_burst(vecs[k].n_rd, $sformatf("vec%0d_data", k));
            settle();
            check_bit($sformatf("vec%0d_empty", k), empty, vecs[k].exp_empty);
        end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        check_bit("overflow_after_drop", wOverflow, 1'b1);
        check_bit("no_underflow_yet", rUnderflow, 1'b0);
`endif

        // read attempts on an empty FIFO must not move anything
        rEn = 1'b1;
        repeat (5) @(posedge rClk);
        #1;
        rEn = 1'b0;
        check_data("underrun_rdata_hold", rData, last_rd);
        check_bit("underrun_empty", empty, 1'b1);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        check_bit("underflow_sticky", rUnderflow, 1'b1);
`endif
        write_burst(1, 4'h5, 1);
        settle();
        read_burst(1, "post_underrun_data");
        settle();
        check_bit("post_underrun_empty", empty, 1'b1);

        mon_on = 1'b1;
        fork
            begin
                int cyc;
                cyc = 0;
                while (wr_acc < 100 && cyc < 3000) begin
                    @(posedge wClk); #1;
                    wEn   = ($urandom_range(0, 3) != 0);
                    wData = W'($urandom);
                    cyc++;
                end
                wEn     = 1'b0;
                wr_done = 1'b1;
                check_bit("rand_writer_in_budget", cyc < 3000, 1'b1);
            end
            begin
                int cyc;
                cyc = 0;
                while (!(wr_done && mq.size() == 0) && cyc < 2500) begin
                    @(posedge rClk); #1;
                    rEn = (rd_acc < 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    cyc++;
                end
                rEn = 1'b0;
                check_bit("rand_reader_in_budget", cyc < 2500, 1'b1);
            end
        join
        settle();
        mon_on = 1'b0;
        check_int("rand_read_count", rd_acc, wr_acc);
        check_int("rand_write_count", wr_acc, 100);
        check_bit("rand_final_empty", empty, 1'b1);
        check_bit("rand_final_full", full, 1'b0);

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        check_bit("overflow_still_set", wOverflow, 1'b1);
`endif
        wRst = 1'b1;
        rRst = 1'b1;
        #30;
        wRst = 1'b0;
        rRst = 1'b0;
        @(posedge rClk); #1;
        check_bit("rereset_empty", empty, 1'b1);
        check_bit("rereset_full", full, 1'b0);
        check_data("rereset_rdata", rData, 4'h0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        check_bit("rereset_overflow", wOverflow, 1'b0);
        check_bit("rereset_underflow", rUnderflow, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
